// File: rtl/mem16k_rr_arbiter.sv
// mem16k_rr_arbiter: two-requester round-robin arbiter and access sequencer
// for the shared 16 KB single-port memory (4 x 4 KB banks, registered read,
// bank output mux driven by the live address).
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rN_valid/we/addr/wdata      requester N command (held until rN_ready)
//   rN_ready                    command accepted at the coming edge (combinational)
//   rN_rsp_valid, rN_rdata      one-cycle read response pulse and captured data
//   mem_addr/mem_data_in/mem_we registered memory command pins
//   mem_data_out                memory read data
module mem16k_rr_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_HOLD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last_grant, last_grant_nxt;
  logic              winner;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_data_in_nxt;
  logic              mem_we_nxt;
  logic              r0_rsp_valid_nxt, r1_rsp_valid_nxt;
  logic [DATA_W-1:0] r0_rdata_nxt, r1_rdata_nxt;

  // State and registered outputs; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_we       <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      last_grant   <= last_grant_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_data_in  <= mem_data_in_nxt;
      mem_we       <= mem_we_nxt;
      r0_rsp_valid <= r0_rsp_valid_nxt;
      r1_rsp_valid <= r1_rsp_valid_nxt;
      r0_rdata     <= r0_rdata_nxt;
      r1_rdata     <= r1_rdata_nxt;
    end
  end

  // Arbitration, next state and next register values
  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    last_grant_nxt   = last_grant;
    mem_addr_nxt     = mem_addr;
    mem_data_in_nxt  = mem_data_in;
    mem_we_nxt       = mem_we;
    r0_rsp_valid_nxt = 1'b0;
    r1_rsp_valid_nxt = 1'b0;
    r0_rdata_nxt     = r0_rdata;
    r1_rdata_nxt     = r1_rdata;
    r0_ready         = 1'b0;
    r1_ready         = 1'b0;

    // Sole valid requester wins; on contention the one not granted last time
    winner = (r0_valid && r1_valid) ? ~last_grant : r1_valid;

    unique case (state)
      IDLE: begin
        r0_ready = r0_valid && !winner;
        r1_ready = r1_valid && winner;
        if (r0_valid || r1_valid) begin
          state_nxt       = CMD;
          owner_nxt       = winner;
          last_grant_nxt  = winner;
          mem_addr_nxt    = winner ? r1_addr  : r0_addr;
          mem_we_nxt      = winner ? r1_we    : r0_we;
          mem_data_in_nxt = winner ? r1_wdata : r0_wdata;
        end
      end
      CMD: begin
        // Memory samples the command at this edge; a read keeps the address for the bank mux
        mem_we_nxt = 1'b0;
        state_nxt  = mem_we ? IDLE : RD_HOLD;
      end
      RD_HOLD: begin
        state_nxt = IDLE;
        if (owner) begin
          r1_rsp_valid_nxt = 1'b1;
          r1_rdata_nxt     = mem_data_out;
        end else begin
          r0_rsp_valid_nxt = 1'b1;
          r0_rdata_nxt     = mem_data_out;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem16k_rr_arbiter.sv
// Bench for mem16k_rr_arbiter: banked registered-read memory device, two
// queue-driven requesters, a transaction-level reference model and a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_mem16k_rr_arbiter;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 16384;
  localparam int          STALL_MAX = 200;
  localparam int          DRAIN_MAX = 4000;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                gap;
    bit                abort;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              r0_valid = 1'b0, r0_we = 1'b0;
  logic [ADDR_W-1:0] r0_addr = '0;
  logic [DATA_W-1:0] r0_wdata = '0;
  logic              r1_valid = 1'b0, r1_we = 1'b0;
  logic [ADDR_W-1:0] r1_addr = '0;
  logic [DATA_W-1:0] r1_wdata = '0;
  logic              r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_we;

  mem16k_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory device: 4 banks with registered outputs, no read on a write cycle,
  // output mux selected by the live address.
  logic [DATA_W-1:0] dev_mem [DEPTH];
  logic [DATA_W-1:0] bank_q  [4];
  assign mem_data_out = bank_q[mem_addr[13:12]];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) dev_mem[i] = 8'(i ^ (i >> 6));
    for (int b = 0; b < 4; b++) bank_q[b] = '0;
    forever begin
      @(posedge clk);
      if (mem_we) dev_mem[mem_addr] <= mem_data_in;
      else        bank_q[mem_addr[13:12]] <= dev_mem[mem_addr];
    end
  end

  // Reference model: transaction timing from the latency rules
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                e = 0, next_ok = 0, rd_edge = 0;
  bit                m_last = 1'b1, rd_pend = 1'b0, rd_owner = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0, exp_addr = '0;
  logic              exp_we = 1'b0;
  logic [DATA_W-1:0] exp_din = '0, exp_rdata0 = '0, exp_rdata1 = '0;
  bit                exp_rsp0 = 1'b0, exp_rsp1 = 1'b0;

  function automatic bit pick();
    if (r0_valid && r1_valid) return !m_last;
    return r1_valid ? 1'b1 : 1'b0;
  endfunction

  function automatic bit exp_ready(input bit n);
    if (e + 1 < next_ok) return 1'b0;
    if (!(n ? r1_valid : r0_valid)) return 1'b0;
    return pick() == n;
  endfunction

  initial begin
    bit n;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'(i ^ (i >> 6));
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; next_ok = 0; m_last = 1'b1; rd_pend = 1'b0;
        exp_addr = '0; exp_we = 1'b0; exp_din = '0;
        exp_rsp0 = 1'b0; exp_rsp1 = 1'b0; exp_rdata0 = '0; exp_rdata1 = '0;
      end else begin
        e++;
        exp_rsp0 = 1'b0;
        exp_rsp1 = 1'b0;
        if (exp_we) begin
          ref_mem[exp_addr] = exp_din;
          exp_we = 1'b0;
        end
        if (rd_pend && e == rd_edge) begin
          rd_pend = 1'b0;
          if (rd_owner) begin exp_rsp1 = 1'b1; exp_rdata1 = ref_mem[rd_addr]; end
          else          begin exp_rsp0 = 1'b1; exp_rdata0 = ref_mem[rd_addr]; end
        end
        if (e >= next_ok && (r0_valid || r1_valid)) begin
          n        = pick();
          m_last   = n;
          exp_addr = n ? r1_addr  : r0_addr;
          exp_we   = n ? r1_we    : r0_we;
          exp_din  = n ? r1_wdata : r0_wdata;
          next_ok  = e + (exp_we ? 2 : 3);
          if (!exp_we) begin
            rd_pend = 1'b1; rd_edge = e + 2; rd_owner = n; rd_addr = exp_addr;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model; also logs responses
  logic [DATA_W-1:0] rsp_q0[$], rsp_q1[$];
  int                rsp_cyc1 = 0;

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      if (rst_n) begin
        chk("r0_ready", 32'(r0_ready), 32'(exp_ready(1'b0)));
        chk("r1_ready", 32'(r1_ready), 32'(exp_ready(1'b1)));
      end
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) chk("mem_data_in", 32'(mem_data_in), 32'(exp_din));
      chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(exp_rsp0));
      chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(exp_rsp1));
      chk("r0_rdata", 32'(r0_rdata), 32'(exp_rdata0));
      chk("r1_rdata", 32'(r1_rdata), 32'(exp_rdata1));
      if (rst_n && r0_rsp_valid) rsp_q0.push_back(r0_rdata);
      if (rst_n && r1_rsp_valid) begin rsp_q1.push_back(r1_rdata); rsp_cyc1 = cyc; end
    end
  end

  // Requester drivers: hold each command until ready, or one cycle if abort
  cmd_t q0[$], q1[$];
  cmd_t cur [2];
  bit   pres [2] = '{1'b0, 1'b0};
  bit   loaded [2] = '{1'b0, 1'b0};
  bit   acc [2];
  int   gapl [2] = '{0, 0};
  int   stall [2] = '{0, 0};
  int   glog_id[$], glog_cyc[$];

  initial forever begin
    @(negedge clk);
    acc[0] = pres[0] && r0_ready && rst_n;
    acc[1] = pres[1] && r1_ready && rst_n;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (pres[n]) begin
        if (acc[n]) begin
          glog_id.push_back(n);
          glog_cyc.push_back(cyc);
          pres[n] = 1'b0;
        end else if (cur[n].abort) begin
          pres[n] = 1'b0;
        end else if (rst_n) begin
          stall[n]++;
          if (stall[n] > STALL_MAX) begin
            checks++;
            errors++;
            $display("FAIL stall: requester %0d not accepted within %0d cycles", n, STALL_MAX);
            pres[n] = 1'b0;
          end
        end
      end
      if (!pres[n] && !loaded[n]) begin
        if (n == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); loaded[0] = 1'b1; gapl[0] = cur[0].gap; end
        if (n == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); loaded[1] = 1'b1; gapl[1] = cur[1].gap; end
      end
      if (loaded[n] && !pres[n]) begin
        if (gapl[n] == 0) begin pres[n] = 1'b1; loaded[n] = 1'b0; stall[n] = 0; end
        else gapl[n]--;
      end
    end
    r0_valid = pres[0]; r0_we = cur[0].we; r0_addr = cur[0].addr; r0_wdata = cur[0].wdata;
    r1_valid = pres[1]; r1_we = cur[1].we; r1_addr = cur[1].addr; r1_wdata = cur[1].wdata;
  end

  task automatic push(input int n, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input int gap, input bit ab);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.gap = gap; c.abort = ab;
    if (n == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  function automatic bit idle();
    return q0.size() == 0 && q1.size() == 0 && !pres[0] && !pres[1] && !loaded[0] && !loaded[1];
  endfunction

  task automatic drain();
    int n = 0;
    while (!idle() && n < DRAIN_MAX) begin @(posedge clk); n++; end
    if (n >= DRAIN_MAX) begin
      checks++;
      errors++;
      $display("FAIL drain: requesters still busy after %0d cycles", DRAIN_MAX);
    end
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    glog_id.delete(); glog_cyc.delete(); rsp_q0.delete(); rsp_q1.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [ADDR_W-1:0] bnd [6] = '{14'h0000, 14'h0FFF, 14'h1000, 14'h1FFF, 14'h2000, 14'h3FFF};

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_data_in", 32'(mem_data_in), 0);
    chk("rst_r0_rsp", 32'(r0_rsp_valid), 0);
    chk("rst_r1_rdata", 32'(r1_rdata), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write by r0, read back by r1
    push(0, 1'b1, 14'h0123, 8'hA5, 0, 1'b0);
    drain();
    clear_logs();
    push(1, 1'b0, 14'h0123, 8'h00, 0, 1'b0);
    drain();
    chk("t1_r1_rdata", 32'(r1_rdata), 'hA5);
    chk("t1_r1_rsp_count", 32'(rsp_q1.size()), 1);
    chk("t1_r0_rsp_count", 32'(rsp_q0.size()), 0);
    chk("t1_rsp_latency", 32'(rsp_cyc1 - glog_cyc[0]), 2);

    // Bank boundaries, read back in reverse
    push(0, 1'b1, 14'h0FFF, 8'h11, 0, 1'b0);
    push(0, 1'b1, 14'h1000, 8'h22, 0, 1'b0);
    push(0, 1'b1, 14'h2FFF, 8'h33, 0, 1'b0);
    push(0, 1'b1, 14'h3FFF, 8'hC3, 0, 1'b0);
    drain();
    clear_logs();
    push(1, 1'b0, 14'h3FFF, 8'h00, 0, 1'b0);
    push(1, 1'b0, 14'h2FFF, 8'h00, 0, 1'b0);
    push(1, 1'b0, 14'h1000, 8'h00, 0, 1'b0);
    push(1, 1'b0, 14'h0FFF, 8'h00, 0, 1'b0);
    drain();
    chk("t2_rd_3fff", 32'(rsp_q1[0]), 'hC3);
    chk("t2_rd_2fff", 32'(rsp_q1[1]), 'h33);
    chk("t2_rd_1000", 32'(rsp_q1[2]), 'h22);
    chk("t2_rd_0fff", 32'(rsp_q1[3]), 'h11);

    // Contention: pattern written by r1 so r0 holds priority next
    for (int i = 0; i < 6; i++) push(1, 1'b1, 14'(14'h0200 + i), 8'(8'h40 + i), 0, 1'b0);
    drain();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 14'(14'h0200 + 2 * i), 8'h00, 0, 1'b0);
      push(1, 1'b0, 14'(14'h0201 + 2 * i), 8'h00, 0, 1'b0);
    end
    drain();
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), 32'(glog_id[i]), 32'(i % 2));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_r0_data%0d", i), 32'(rsp_q0[i]), 32'(8'h40 + 2 * i));
      chk($sformatf("t3_r1_data%0d", i), 32'(rsp_q1[i]), 32'(8'h41 + 2 * i));
    end

    // Lone requester streaming writes
    clear_logs();
    for (int i = 0; i < 4; i++) push(1, 1'b1, 14'(14'h3000 + i), 8'(8'h90 + i), 0, 1'b0);
    drain();
    chk("t4_accepts", 32'(glog_id.size()), 4);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_spacing%0d", i), 32'(glog_cyc[i + 1] - glog_cyc[i]), 2);
    clear_logs();
    for (int i = 0; i < 4; i++) push(1, 1'b0, 14'(14'h3000 + i), 8'h00, 0, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) chk($sformatf("t4_rd%0d", i), 32'(rsp_q1[i]), 32'(8'h90 + i));

    // Reset during RD_HOLD
    clear_logs();
    push(0, 1'b0, 14'h0123, 8'h00, 0, 1'b0);
    n = 0;
    while (glog_id.size() == 0 && n < 100) begin @(posedge clk); #2; n++; end
    chk("t5_accept", 32'(glog_id.size()), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_addr", 32'(mem_addr), 0);
    chk("t5_mem_we", 32'(mem_we), 0);
    chk("t5_r0_rsp", 32'(r0_rsp_valid), 0);
    chk("t5_r0_rdata", 32'(r0_rdata), 0);
    chk("t5_r1_rdata", 32'(r1_rdata), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("t5_no_rsp", 32'(rsp_q0.size() + rsp_q1.size()), 0);
    clear_logs();
    push(0, 1'b0, 14'h0123, 8'h00, 0, 1'b0);
    push(1, 1'b0, 14'h1000, 8'h00, 0, 1'b0);
    drain();
    chk("t5_first_grant", 32'(glog_id[0]), 0);
    chk("t5_r0_data", 32'(rsp_q0[0]), 'hA5);
    chk("t5_r1_data", 32'(rsp_q1[0]), 'h22);

    // r1 valid for a single cycle while busy: never accepted
    clear_logs();
    push(0, 1'b1, 14'h0400, 8'h5A, 0, 1'b0);
    push(1, 1'b1, 14'h0400, 8'hEE, 1, 1'b1);
    drain();
    chk("t6_accepts", 32'(glog_id.size()), 1);
    chk("t6_grant", 32'(glog_id[0]), 0);
    clear_logs();
    push(0, 1'b0, 14'h0400, 8'h00, 0, 1'b0);
    drain();
    chk("t6_readback", 32'(rsp_q0[0]), 'h5A);

    // Randomized traffic from both requesters
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 2; r++) begin
        logic [ADDR_W-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 5)] : 14'($urandom);
        push(r, 1'($urandom_range(0, 1)), a, 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
